// File: rtl/prog_timer_pkg.sv
// Shared types and constants for the programmable down-counting timer.
// The FSM state enum and the latched mode encoding live here.
package timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/prog_timer_if.sv
// Control/status bundle of prog_timer: load strobe, enable and the
// registered trigger/count/running outputs.
interface prog_timer_if #(
    parameter int WIDTH = 5,
    parameter int PRE_W = 4
);

    logic             enable;
    logic             valid;
    logic [WIDTH-1:0] value;
    logic             mode;
    logic [PRE_W-1:0] prescale;
    logic             trigger;
    logic [WIDTH-1:0] count;
    logic             running;

    modport master (
        output enable, valid, value, mode, prescale,
        input  trigger, count, running
    );

    modport slave (
        input  enable, valid, value, mode, prescale,
        output trigger, count, running
    );

endinterface

// File: rtl/prog_timer_fsm.sv
// IDLE/RUN control of prog_timer plus the registered one-cycle trigger.
// A load always overrides a tick arriving in the same cycle.
module prog_timer_fsm
    import timer_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         valid,
    input  logic         value_nz,
    input  logic         tick,
    input  logic         last,
    input  logic         mode_q,
    output timer_state_t state,
    output logic         trigger
);

    timer_state_t state_q, state_d;
    logic         trigger_q, trigger_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            trigger_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            trigger_q <= trigger_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        trigger_d = 1'b0;
        if (valid) begin
            state_d = value_nz ? RUN : IDLE;
        end else if (tick && last) begin
            // Expiry: one-shot drops back to IDLE, periodic keeps running.
            trigger_d = 1'b1;
            if (mode_q == MODE_ONESHOT) begin
                state_d = IDLE;
            end
        end
    end

    assign state   = state_q;
    assign trigger = trigger_q;

endmodule

// File: rtl/prog_timer.sv
// Parametrised down-counting timer with prescaler and one-shot/periodic
// auto-reload; the datapath lives here, control in prog_timer_fsm.
module prog_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int PRE_W = 4
) (
    input  logic     clk,
    input  logic     reset,
    prog_timer_if.slave bus
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

    timer_state_t state;
    logic         trigger;
    logic         tick;
    logic         last;
    logic         value_nz;

    assign tick     = (state == RUN) && bus.enable && (pre_cnt_q == pre_q);
    assign last     = (cnt_q == WIDTH'(1));
    assign value_nz = |bus.value;

    prog_timer_fsm u_fsm (
        .clk      (clk),
        .reset    (reset),
        .valid    (bus.valid),
        .value_nz (value_nz),
        .tick     (tick),
        .last     (last),
        .mode_q   (mode_q),
        .state    (state),
        .trigger  (trigger)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            reload_q  <= '0;
            mode_q    <= MODE_ONESHOT;
            pre_q     <= '0;
            pre_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
            pre_q     <= pre_d;
            pre_cnt_q <= pre_cnt_d;
        end
    end

    // cnt is never 0 while in RUN, so the decrement cannot underflow.
    always_comb begin
        cnt_d     = cnt_q;
        reload_d  = reload_q;
        mode_d    = mode_q;
        pre_d     = pre_q;
        pre_cnt_d = pre_cnt_q;
        if (bus.valid) begin
            cnt_d     = bus.value;
            reload_d  = bus.value;
            mode_d    = bus.mode;
            pre_d     = bus.prescale;
            pre_cnt_d = '0;
        end else if (state == RUN && bus.enable) begin
            if (tick) begin
                pre_cnt_d = '0;
                if (last) begin
                    cnt_d = (mode_q == MODE_PERIODIC) ? reload_q : '0;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end else begin
                pre_cnt_d = pre_cnt_q + PRE_W'(1);
            end
        end
    end

    assign bus.trigger = trigger;
    assign bus.count   = cnt_q;
    assign bus.running = (state == RUN);

endmodule

// File: tb/tb_prog_timer.sv
// Scoreboard bench for prog_timer: the stimulus side predicts each cycle's
// outputs from elapsed enabled cycles and queues them for the monitor.
module tb_prog_timer;
    import timer_pkg::*;

    localparam int W  = 8;
    localparam int PW = 4;

    typedef struct packed {
        logic         trig;
        logic [W-1:0] cnt;
        logic         run;
    } exp_t;

    logic clk;
    logic reset;
    int   testsRun;
    int   testsFailed;
    exp_t expQ[$];

    bit mRun;
    bit mMode;
    bit mTrig;
    int mN;
    int mP;
    int mE;
    int mCnt;

    prog_timer_if #(.WIDTH(W), .PRE_W(PW)) bus ();

    prog_timer #(.WIDTH(W), .PRE_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic modelClear();
        mRun  = 1'b0;
        mMode = 1'b0;
        mTrig = 1'b0;
        mN    = 0;
        mP    = 0;
        mE    = 0;
        mCnt  = 0;
    endtask

    // Expiry happens once N*(P+1) enabled RUN cycles have elapsed since the
    // load or the previous reload; the count is N minus the completed ticks.
    task automatic applyStimulus(input logic en, input logic v, input int val,
                                 input logic md, input int ps);
        bus.enable   = en;
        bus.valid    = v;
        bus.value    = W'(val);
        bus.mode     = md;
        bus.prescale = PW'(ps);
        mTrig = 1'b0;
        if (v) begin
            mN    = val;
            mP    = ps;
            mMode = md;
            mE    = 0;
            mCnt  = val;
            mRun  = (val != 0);
        end else if (mRun && en) begin
            mE++;
            if (mE == mN * (mP + 1)) begin
                mTrig = 1'b1;
                mE    = 0;
                if (mMode == MODE_PERIODIC) begin
                    mCnt = mN;
                end else begin
                    mCnt = 0;
                    mRun = 1'b0;
                end
            end else begin
                mCnt = mN - mE / (mP + 1);
            end
        end
        expQ.push_back('{trig: mTrig, cnt: W'(mCnt), run: mRun});
        @(posedge clk);
        #4;
    endtask

    task automatic runCycles(input int n, input logic en);
        for (int i = 0; i < n; i++) begin
            applyStimulus(en, 1'b0, 0, 1'b0, 0);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        checkOutput("async_reset_count", 32'(bus.count), 32'd0);
        checkOutput("async_reset_running", 32'(bus.running), 32'd0);
        checkOutput("async_reset_trigger", 32'(bus.trigger), 32'd0);
        #1;
        reset = 1'b0;
        modelClear();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("trigger", 32'(bus.trigger), 32'(e.trig));
                checkOutput("count", 32'(bus.count), 32'(e.cnt));
                checkOutput("running", 32'(bus.running), 32'(e.run));
            end
        end
    end

    initial begin
        int r;
        testsRun    = 0;
        testsFailed = 0;
        modelClear();
        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.valid    = 1'b0;
        bus.value    = '0;
        bus.mode     = 1'b0;
        bus.prescale = '0;
        @(posedge clk);
        @(posedge clk);
        #4;
        checkOutput("reset_count", 32'(bus.count), 32'd0);
        checkOutput("reset_running", 32'(bus.running), 32'd0);
        checkOutput("reset_trigger", 32'(bus.trigger), 32'd0);
        reset = 1'b0;

        // One-shot, no prescale: 5,4,3,2,1,0 with a single trigger.
        applyStimulus(1'b1, 1'b1, 5, MODE_ONESHOT, 0);
        runCycles(8, 1'b1);

        // Periodic with prescale: trigger every 9 cycles over 4 periods.
        applyStimulus(1'b1, 1'b1, 3, MODE_PERIODIC, 2);
        runCycles(38, 1'b1);

        // Enable gating delays expiry by the frozen cycles.
        applyStimulus(1'b1, 1'b1, 4, MODE_ONESHOT, 1);
        runCycles(3, 1'b1);
        runCycles(6, 1'b0);
        runCycles(10, 1'b1);

        // Load colliding with the expiring tick, then load of zero.
        applyStimulus(1'b1, 1'b1, 2, MODE_ONESHOT, 0);
        runCycles(1, 1'b1);
        applyStimulus(1'b1, 1'b1, 6, MODE_ONESHOT, 0);
        runCycles(8, 1'b1);
        applyStimulus(1'b1, 1'b1, 0, MODE_PERIODIC, 0);
        runCycles(3, 1'b1);

        // Reset mid-run with count 7, then stay idle.
        applyStimulus(1'b1, 1'b1, 9, MODE_PERIODIC, 0);
        runCycles(2, 1'b1);
        checkOutput("pre_reset_count", 32'(bus.count), 32'd7);
        doReset();
        runCycles(4, 1'b1);

        // Full-width periodic reload from 255.
        applyStimulus(1'b1, 1'b1, 255, MODE_PERIODIC, 0);
        runCycles(520, 1'b1);

        // Randomized mix of loads, enable gaps and resets.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                doReset();
            end
            if (r < 10) begin
                applyStimulus($urandom_range(0, 9) != 0, 1'b1,
                              int'($urandom_range(0, 12)), logic'($urandom_range(0, 1)),
                              int'($urandom_range(0, 3)));
            end else begin
                applyStimulus($urandom_range(0, 4) != 0, 1'b0, 0, 1'b0, 0);
            end
        end

        repeat (2) @(posedge clk);
        #3;
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
